// File: rtl/ahb_ext_sram_ctrl_pkg.sv
// Shared types and constants for the external SRAM AHB-Lite slave.
package ahb_ext_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WCAP,
        WR,
        WREC,
        DONE,
        ERR1,
        ERR2
    } statetype;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

endpackage

// File: rtl/ahb_ext_sram_ctrl_waitcnt.sv
// 4-bit loadable down-counter timing SRAM read and write strobe phases.
// It stops at zero, and done_o flags the last cycle of a timed phase.
module ext_sram_waitcnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load has priority; otherwise count down while enabled, holding at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/ahb_ext_sram_ctrl.sv
// AHB-Lite slave for the external region, driving an asynchronous
// single-port SRAM with timed read/write strobes, byte-lane writes and a
// write-to-read turnaround. Addresses beyond the SRAM depth get a
// two-cycle ERROR response and never touch the SRAM.
module ahb_ext_sram_ctrl
    import ahb_ext_sram_ctrl_pkg::*;
#(
    parameter int AHBW      = 64,
    parameter int ADDR_BITS = 20,
    parameter int PA_BITS   = 34,
    parameter int WAIT_RD   = 2,
    parameter int WAIT_WR   = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSELEXT,
    input  logic [PA_BITS-1:0]   HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic                 HREADY,
    input  logic [AHBW-1:0]      HWDATA,
    input  logic [AHBW/8-1:0]    HWSTRB,
    output logic [AHBW-1:0]      HRDATAEXT,
    output logic                 HREADYEXT,
    output logic                 HRESPEXT,
    output logic [ADDR_BITS-1:0] SRAMA,
    output logic [AHBW-1:0]      SRAMDQOut,
    input  logic [AHBW-1:0]      SRAMDQIn,
    output logic                 SRAMDQOE,
    output logic                 SRAMCEb,
    output logic                 SRAMOEb,
    output logic                 SRAMWEb,
    output logic [AHBW/8-1:0]    SRAMBEb
);

    localparam int NB  = AHBW / 8;
    localparam int OFF = $clog2(NB);
    localparam int TOP = ADDR_BITS + OFF;

    statetype             state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic [AHBW-1:0]      dqout_q;
    logic [NB-1:0]        beb_q;
    logic [AHBW-1:0]      rdata_q;

    logic     accept;
    logic     ready_st;
    logic     start;
    logic     oor;
    statetype start_st;
    logic     cnt_load;
    logic [3:0] cnt_val;
    logic     cnt_en;
    logic     cnt_done;

    // Size and byte offset do not affect a full-width word access.
    logic unused_ok;
    assign unused_ok = ^{HSIZE, HADDR[OFF-1:0]};

    assign accept   = HSELEXT & HREADY & ((HTRANS & HTRANS_NONSEQ) != HTRANS_IDLE);
    assign ready_st = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
    assign start    = accept & ready_st;
    assign oor      = |HADDR[PA_BITS-1:TOP];
    assign start_st = oor ? ERR1 : (HWRITE ? WCAP : RD);

    // A read is timed from its accept; a write only once its data is captured.
    assign cnt_load = (start && !oor && !HWRITE) || (state_q == WCAP);
    assign cnt_val  = (state_q == WCAP) ? 4'(WAIT_WR) : 4'(WAIT_RD);
    assign cnt_en   = (state_q == RD) || (state_q == WR);

    ext_sram_waitcnt u_waitcnt (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .done_o     (cnt_done)
    );

    // Next-state and SRAM strobe decode; strobes are released by default.
    always_comb begin
        state_d   = state_q;
        HREADYEXT = 1'b0;
        HRESPEXT  = 1'b0;
        SRAMCEb   = 1'b1;
        SRAMOEb   = 1'b1;
        SRAMWEb   = 1'b1;
        SRAMDQOE  = 1'b0;
        SRAMBEb   = '1;
        case (state_q)
            IDLE: begin
                HREADYEXT = 1'b1;
                if (start) state_d = start_st;
            end
            RD: begin
                SRAMCEb = 1'b0;
                SRAMOEb = 1'b0;
                SRAMBEb = '0;
                if (cnt_done) state_d = DONE;
            end
            WCAP: begin
                state_d = WR;
            end
            WR: begin
                SRAMCEb  = 1'b0;
                SRAMWEb  = 1'b0;
                SRAMDQOE = 1'b1;
                SRAMBEb  = beb_q;
                if (cnt_done) state_d = WREC;
            end
            WREC: begin
                state_d = DONE;
            end
            DONE: begin
                HREADYEXT = 1'b1;
                // Keep the read strobes up so back-to-back reads show no OEb gap.
                if (!write_q) begin
                    SRAMCEb = 1'b0;
                    SRAMOEb = 1'b0;
                    SRAMBEb = '0;
                end
                state_d = start ? start_st : IDLE;
            end
            ERR1: begin
                HRESPEXT = 1'b1;
                state_d  = ERR2;
            end
            ERR2: begin
                HRESPEXT  = 1'b1;
                HREADYEXT = 1'b1;
                state_d   = start ? start_st : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address latch, write capture and read-data capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            dqout_q <= '0;
            beb_q   <= '1;
            rdata_q <= '0;
        end else begin
            if (start) begin
                addr_q  <= HADDR[TOP-1:OFF];
                write_q <= HWRITE;
            end
            if (state_q == WCAP) begin
                dqout_q <= HWDATA;
                beb_q   <= ~HWSTRB;
            end
            if ((state_q == RD) && cnt_done) begin
                rdata_q <= SRAMDQIn;
            end
        end
    end

    assign SRAMA     = addr_q;
    assign SRAMDQOut = dqout_q;
    assign HRDATAEXT = rdata_q;

endmodule

// File: doc/ahb_ext_sram_ctrl.md
Name: ahb_ext_sram_ctrl

Overview:
AHB-Lite slave that services the external region, selected by HSELEXT from the uncore address decoder. It returns HRDATAEXT, HREADYEXT and HRESPEXT to the uncore read/ready mux. It drives an asynchronous single-port SRAM through a small FSM with parameterised read/write wait states, byte-lane writes and a write-to-read bus turnaround. It also raises a two-cycle AHB error for addresses beyond the SRAM depth.

Parameters:
AHBW, 64, AHB data width in bits; SRAM data width equals AHBW.
ADDR_BITS, 20, SRAM word-address width; depth is 2^ADDR_BITS words.
PA_BITS, 34, physical address width of HADDR.
WAIT_RD, 2, extra read-access cycles (0..15).
WAIT_WR, 1, extra WEb-low cycles beyond one (0..15).

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
HSELEXT  in  1  region select from uncore decoder
HADDR  in  PA_BITS  address-phase address
HTRANS  in  2  transfer type
HWRITE  in  1  write when 1
HSIZE  in  3  transfer size
HREADY  in  1  bus-wide ready (qualifies address phase)
HWDATA  in  AHBW  write data (data phase)
HWSTRB  in  AHBW/8  write byte strobes (data phase)
HRDATAEXT  out  AHBW  read data
HREADYEXT  out  1  slave ready
HRESPEXT  out  1  error response
SRAMA  out  ADDR_BITS  SRAM word address
SRAMDQOut  out  AHBW  SRAM write data
SRAMDQIn  in  AHBW  SRAM read data
SRAMDQOE  out  1  DQ pad output enable
SRAMCEb, SRAMOEb, SRAMWEb  out  1  active-low strobes
SRAMBEb  out  AHBW/8  active-low byte enables

Behaviour:
- Reset state: HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, SRAMA=0, SRAMDQOut=0, SRAMDQOE=0, SRAMCEb/OEb/WEb=1, SRAMBEb=all 1, FSM=IDLE. Reset asserted mid-transfer takes effect on the next edge; all strobes are released at that edge.
- Accept condition: HSELEXT & HREADY & HTRANS[1] (NONSEQ/SEQ). The accept latches HADDR, HWRITE and an out-of-range flag. Out of range means any HADDR bit above ADDR_BITS+log2(AHBW/8)-1 is set.
- IDLE/BUSY transfers and unselected cycles get a zero-wait OKAY: HREADYEXT=1, HRESPEXT=0.
- Word address: SRAMA = HADDR[ADDR_BITS+log2(AHBW/8)-1 : log2(AHBW/8)].
- FSM states and transitions:
  - IDLE: wait for accept.
  - RD: CEb=OEb=0, BEb=0, DQOE=0. A counter runs WAIT_RD+1 cycles with HREADYEXT=0. On the last RD cycle, SRAMDQIn is registered into HRDATAEXT. Go to DONE.
  - WCAP: one cycle, HREADYEXT=0. Registers HWDATA into SRAMDQOut, ~HWSTRB into BEb, and sets DQOE=1.
  - WR: CEb=WEb=0 for WAIT_WR+1 cycles, HREADYEXT=0, DQOE=1.
  - WREC: WEb=1, CEb=1, DQOE=0, HREADYEXT=0. Provides address/data hold and write-to-read turnaround. Go to DONE.
  - DONE: HREADYEXT=1; read data is valid on HRDATAEXT. An accept in DONE starts the next transfer (pipelined); otherwise go to IDLE.
  - ERR1: HRESPEXT=1, HREADYEXT=0, no SRAM strobes.
  - ERR2: HRESPEXT=1, HREADYEXT=1. Then IDLE, or a new transfer if accepted in this cycle.
- Latency, data-phase cycles including the final ready cycle: read = WAIT_RD+2; write = WAIT_WR+4; error = 2.
- HRDATAEXT holds its last value between reads. Writes leave it unchanged.
- Back-to-back read→read: the second read's SRAMA/OEb are driven the cycle after DONE, with no gap in OEb. Write→read is always separated by WREC, so DQOE=0 and OEb=1 for at least one cycle.
- The counter is 4 bits. Loaded values are WAIT_RD or WAIT_WR; it reaches 0 without wrap.

Decomposition:
- Package entries: enum statetype {IDLE, RD, WCAP, WR, WREC, DONE, ERR1, ERR2}; localparams HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10.
- One sub-module: ext_sram_waitcnt, a 4-bit loadable down-counter with a done flag, shared by RD and WR.

Test Plan:
- Reset: hold HRESET 3 cycles mid-write (WEb=0) → next edge WEb=1, DQOE=0, HREADYEXT=1, HRDATAEXT=0.
- Read, WAIT_RD=2: preload word 0x5 = 64'hDEADBEEF_01234567, read HADDR=0x28 → HREADYEXT low 3 cycles, high on 4th, HRDATAEXT=64'hDEADBEEF_01234567, SRAMA=0x5.
- Byte write, WAIT_WR=1: write HADDR=0x10, HWSTRB=8'h0F, HWDATA=64'h11223344_55667788 → BEb=8'hF0, WEb low exactly 2 cycles, ready on 5th cycle. Readback gives upper bytes unchanged, lower = 0x55667788.
- Pipelined write→read→read: read issued in write's DONE → WREC shows DQOE=0, OEb=1. Reads return correct data; second read starts the cycle after first DONE.
- Out of range: HADDR bit 23 set (ADDR_BITS=20, AHBW=64) → HRESPEXT=1 for 2 cycles, HREADYEXT 0 then 1, CEb stays 1.
- HTRANS=IDLE with HSELEXT=1 → HREADYEXT=1, HRESPEXT=0 same cycle, no strobes.
